// File: rtl/jtag_pkg.sv
// Shared JTAG instruction-register constants: default IR length, IR capture
// pattern and the opcode encodings (BYPASS is all-ones at any width).
package jtag_pkg;
  localparam int         IR_WIDTH_DEF = 4;
  localparam logic [1:0] IR_CAPTURE   = 2'b01;

  localparam int OP_EXTEST = 0;
  localparam int OP_SAMPLE = 1;
  localparam int OP_INTEST = 2;
  localparam int OP_IDCODE = 3;
endpackage

// File: rtl/jtag_instr_decode.sv
// Combinational instruction decode to one-hot DR select and boundary mode.
// IDCODE decode exists only when JTAG_IDCODE_EN is defined.
module jtag_instr_decode
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic [IR_WIDTH-1:0] instr_i,
  output logic                sel_bypass_o,
  output logic                sel_idcode_o,
  output logic                sel_bsr_o,
  output logic                mode_o
);
  logic is_extest, is_sample, is_intest, is_idcode;

  assign is_extest = (instr_i == IR_WIDTH'(OP_EXTEST));
  assign is_sample = (instr_i == IR_WIDTH'(OP_SAMPLE));
  assign is_intest = (instr_i == IR_WIDTH'(OP_INTEST));
`ifdef JTAG_IDCODE_EN
  assign is_idcode = (instr_i == IR_WIDTH'(OP_IDCODE));
`else
  assign is_idcode = 1'b0;
`endif

  // Undefined opcodes fall through to BYPASS, keeping the selects one-hot.
  assign sel_bsr_o    = is_extest | is_sample | is_intest;
  assign sel_idcode_o = is_idcode;
  assign sel_bypass_o = ~(is_extest | is_sample | is_intest | is_idcode);
  assign mode_o       = is_extest | is_intest;
endmodule

// File: rtl/jtag_instruction_register.sv
// JTAG IR capture/shift/update, bypass and IDCODE data registers, TDO mux.
// Define JTAG_IDCODE_EN to include the IDCODE register and reset-to-IDCODE.
module jtag_instruction_register
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = IR_WIDTH_DEF,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TDI,
  input  logic                CaptureIR,
  input  logic                ShiftIR,
  input  logic                UpdateIR,
  input  logic                CaptureDR,
  input  logic                ShiftDR,
  input  logic                UpdateDR,
  input  logic                BsrTdo,
  output logic                TDO,
  output logic                TdoEn,
  output logic [IR_WIDTH-1:0] InstrOut,
  output logic                SelBypass,
  output logic                SelIdcode,
  output logic                SelBsr,
  output logic                Mode
);
  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] INSTR_RST = IR_WIDTH'(OP_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] INSTR_RST = '1;
`endif

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic                dr_tdo;

  // Update is only honoured when no capture/shift is asserted alongside it.
  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    if (CaptureIR)     ir_shift_d = IR_CAP;
    else if (ShiftIR)  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
    else if (UpdateIR) instr_d    = ir_shift_q;
  end

  always_comb begin
    bypass_d = bypass_q;
    if (CaptureDR && SelBypass)    bypass_d = 1'b0;
    else if (ShiftDR && SelBypass) bypass_d = TDI;
  end

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_shift_q <= IR_CAP;
      instr_q    <= INSTR_RST;
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_q, id_d;

  always_comb begin
    id_d = id_q;
    if (CaptureDR && SelIdcode)    id_d = IDCODE_VALUE;
    else if (ShiftDR && SelIdcode) id_d = {TDI, id_q[31:1]};
  end

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) id_q <= IDCODE_VALUE;
    else       id_q <= id_d;
  end

  always_comb begin
    dr_tdo = BsrTdo;
    if (SelBypass)      dr_tdo = bypass_q;
    else if (SelIdcode) dr_tdo = id_q[0];
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, UpdateDR};
`else
  always_comb begin
    dr_tdo = BsrTdo;
    if (SelBypass) dr_tdo = bypass_q;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, UpdateDR, IDCODE_VALUE};
`endif

  // TDO is combinational so the pre-shift LSB appears in the first shift cycle.
  always_comb begin
    TDO = 1'b0;
    if (ShiftIR)      TDO = ir_shift_q[0];
    else if (ShiftDR) TDO = dr_tdo;
  end

  assign TdoEn    = ShiftIR | ShiftDR;
  assign InstrOut = instr_q;

  jtag_instr_decode #(.IR_WIDTH(IR_WIDTH)) u_dec (
    .instr_i      (instr_q),
    .sel_bypass_o (SelBypass),
    .sel_idcode_o (SelIdcode),
    .sel_bsr_o    (SelBsr),
    .mode_o       (Mode)
  );
endmodule
